// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter.
//   DEF_DATA_WIDTH / DEF_ADDRESS_WIDTH : default RAM geometry
//   tag_t                              : per-port pending-read tag {valid, id}
//   rr_next(req, ptr, n)               : returns {found, index} of the first set
//                                        request at or after ptr, modulo n
package dpram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_ADDRESS_WIDTH = 4;
    localparam int unsigned MAX_REQ           = 8;
    localparam int unsigned ID_WIDTH          = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

    function automatic logic [ID_WIDTH:0] rr_next(
        input logic [MAX_REQ-1:0]  req,
        input logic [ID_WIDTH-1:0] ptr,
        input int unsigned         n
    );
        logic [ID_WIDTH:0] res;
        int unsigned       idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !res[ID_WIDTH] && req[idx[ID_WIDTH-1:0]]) begin
                res = {1'b1, idx[ID_WIDTH-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_arbiter_pick.sv
// Combinational round-robin pick of the first two active requesters.
//   req   : request vector
//   ptr   : scan start index
//   hit1  : cand1 valid (first request in scan order)
//   cand1 : index of first request
//   hit2  : cand2 valid (second request in scan order)
//   cand2 : index of second request
module dpram_rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       hit1,
    output logic [$clog2(NUM_REQ)-1:0] cand1,
    output logic                       hit2,
    output logic [$clog2(NUM_REQ)-1:0] cand2
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] req_rest;
    logic [ID_WIDTH:0]  p1;
    logic [ID_WIDTH:0]  p2;

    // The second candidate is the first hit once cand1 is masked out,
    // which is the next request after cand1 in scan order.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        p1                     = rr_next(req_ext, ID_WIDTH'(ptr), NUM_REQ);
        req_rest               = req_ext;
        if (p1[ID_WIDTH]) begin
            req_rest[p1[ID_WIDTH-1:0]] = 1'b0;
        end
        p2    = rr_next(req_rest, ID_WIDTH'(ptr), NUM_REQ);
        hit1  = p1[ID_WIDTH];
        cand1 = PW'(p1[ID_WIDTH-1:0]);
        hit2  = p2[ID_WIDTH];
        cand2 = PW'(p2[ID_WIDTH-1:0]);
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing the two ports of dp_ram among NUM_REQ clients.
// Up to two grants per cycle (port 1 = first in scan order, port 2 = second);
// same-address pairs involving a write are serialised. Read data returns to
// the requester the cycle after its grant.
// Optional feature macro: DPRAM_ARB_CONFLICT_CNT_EN adds output conflict_cnt.
//   clk, rst            : clock, async active-high reset
//   req, wr_req         : per-requester request / write flag
//   addr_req, wdata_req : flat per-requester address / write data
//   gnt                 : combinational grant
//   rvalid, rdata       : per-requester read return
//   en, wr1, wr2, add_1, add_2, data_1, data_2 : RAM controls
//   out_1, out_2        : RAM read data
//   conflict_cnt        : saturating count of deferred conflicts (optional)
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               wr_req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_req,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata,
    output logic                             en,
    output logic                             wr1,
    output logic                             wr2,
    output logic [ADDRESS_WIDTH-1:0]         add_1,
    output logic [ADDRESS_WIDTH-1:0]         add_2,
    output logic [DATA_WIDTH-1:0]            data_1,
    output logic [DATA_WIDTH-1:0]            data_2,
    input  logic [DATA_WIDTH-1:0]            out_1,
    input  logic [DATA_WIDTH-1:0]            out_2
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]                      conflict_cnt
`endif
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0]              ptr, ptr_next;
    logic [PW-1:0]              cand1, cand2;
    logic                       hit1, hit2;
    logic                       conflict, use1, use2;
    logic                       w1, w2;
    logic [ADDRESS_WIDTH-1:0]   a1, a2;
    logic [ADDRESS_WIDTH-1:0]   add_1_q, add_2_q;
    logic [PW-1:0]              r1_id, r2_id;
    tag_t                       tag1, tag2;
    logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q;

    dpram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .hit1  (hit1),
        .cand1 (cand1),
        .hit2  (hit2),
        .cand2 (cand2)
    );

    always_comb begin
        a1       = addr_req[cand1*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        a2       = addr_req[cand2*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w1       = wr_req[cand1];
        w2       = wr_req[cand2];
        conflict = hit1 && hit2 && (a1 == a2) && (w1 || w2);
        use1     = hit1 && !rst;
        use2     = hit2 && !conflict && !rst;

        gnt = '0;
        if (use1) gnt[cand1] = 1'b1;
        if (use2) gnt[cand2] = 1'b1;

        en     = use1 || use2;
        wr1    = use1 && w1;
        wr2    = use2 && w2;
        // An idle port keeps presenting its last address.
        add_1  = use1 ? a1 : add_1_q;
        add_2  = use2 ? a2 : add_2_q;
        data_1 = wr1 ? wdata_req[cand1*DATA_WIDTH +: DATA_WIDTH] : '0;
        data_2 = wr2 ? wdata_req[cand2*DATA_WIDTH +: DATA_WIDTH] : '0;

        ptr_next = ptr;
        if (use2) begin
            ptr_next = PW'((32'(cand2) + 32'd1) % NUM_REQ);
        end else if (use1) begin
            ptr_next = PW'((32'(cand1) + 32'd1) % NUM_REQ);
        end
    end

    // Read return: RAM data is valid the cycle after the access, so the
    // tagged slot passes out_x straight through and then holds it.
    always_comb begin
        r1_id  = PW'(tag1.id);
        r2_id  = PW'(tag2.id);
        rvalid = '0;
        rdata  = rdata_q;
        if (tag1.valid) begin
            rvalid[r1_id]                          = 1'b1;
            rdata[r1_id*DATA_WIDTH +: DATA_WIDTH]  = out_1;
        end
        if (tag2.valid) begin
            rvalid[r2_id]                          = 1'b1;
            rdata[r2_id*DATA_WIDTH +: DATA_WIDTH]  = out_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            add_1_q <= '0;
            add_2_q <= '0;
            tag1    <= '0;
            tag2    <= '0;
            rdata_q <= '0;
        end else begin
            ptr     <= ptr_next;
            add_1_q <= add_1;
            add_2_q <= add_2;
            tag1    <= '{valid: use1 && !w1, id: ID_WIDTH'(cand1)};
            tag2    <= '{valid: use2 && !w2, id: ID_WIDTH'(cand2)};
            rdata_q <= rdata;
        end
    end

`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Self-checking bench for dpram_arbiter: directed table, corner sequences
// (fairness rotation, asynchronous reset mid-read) and random traffic
// compared against a queue-based behavioural model with a behavioural RAM.
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, wr_req;
    logic [N*AW-1:0] addr_req;
    logic [N*DW-1:0] wdata_req;
    logic [N-1:0]  gnt, rvalid;
    logic [N*DW-1:0] rdata;
    logic          en, wr1, wr2;
    logic [AW-1:0] add_1, add_2;
    logic [DW-1:0] data_1, data_2;
    logic [DW-1:0] out_1 = '0;
    logic [DW-1:0] out_2 = '0;
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    logic [15:0]   conflict_cnt;
`endif

    dpram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_req(wr_req), .addr_req(addr_req),
        .wdata_req(wdata_req), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .en(en), .wr1(wr1), .wr2(wr2), .add_1(add_1), .add_2(add_2),
        .data_1(data_1), .data_2(data_2), .out_1(out_1), .out_2(out_2)
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM, synchronous read.
    logic [DW-1:0] ram [16] = '{default: '0};
    always @(posedge clk) begin
        if (en) begin
            if (wr1) ram[add_1] <= data_1;
            if (wr2) ram[add_2] <= data_2;
            out_1 <= ram[add_1];
            out_2 <= ram[add_2];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_ptr;
    logic [DW-1:0] m_mem [16] = '{default: '0};
    logic [DW-1:0] m_hold [N];
    logic [AW-1:0] m_last1, m_last2;
    int            m_cc;
    int            pend_id[$];
    logic [DW-1:0] pend_data[$];

    int            e_c1, e_c2;
    logic          e_conf;
    logic [N-1:0]  e_gnt, e_rvalid;
    logic          e_en, e_wr1, e_wr2;
    logic [AW-1:0] e_add1, e_add2;
    logic [DW-1:0] e_d1, e_d2;
    logic [N*DW-1:0] e_rdata;

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(addr_req >> (i * AW));
    endfunction
    function automatic logic [DW-1:0] wd_of(input int i);
        return DW'(wdata_req >> (i * DW));
    endfunction
    function automatic logic is_wr(input int i);
        return 1'(wr_req >> i);
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_last1 = '0; m_last2 = '0; m_cc = 0;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        pend_id = {}; pend_data = {};
    endtask

    task automatic model_eval();
        int order[$];
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req[idx]) order.push_back(idx);
        end
        e_c1 = -1; e_c2 = -1; e_conf = 1'b0;
        if (order.size() > 0) e_c1 = order[0];
        if (order.size() > 1) begin
            if (addr_of(order[0]) == addr_of(order[1]) && (is_wr(order[0]) || is_wr(order[1])))
                e_conf = 1'b1;
            else
                e_c2 = order[1];
        end
        e_gnt = '0;
        if (e_c1 >= 0) e_gnt = e_gnt | (N'(1) << e_c1);
        if (e_c2 >= 0) e_gnt = e_gnt | (N'(1) << e_c2);
        e_en   = (e_c1 >= 0);
        e_wr1  = (e_c1 >= 0) && is_wr(e_c1);
        e_wr2  = (e_c2 >= 0) && is_wr(e_c2);
        e_add1 = (e_c1 >= 0) ? addr_of(e_c1) : m_last1;
        e_add2 = (e_c2 >= 0) ? addr_of(e_c2) : m_last2;
        e_d1   = e_wr1 ? wd_of(e_c1) : '0;
        e_d2   = e_wr2 ? wd_of(e_c2) : '0;
        e_rvalid = '0;
        e_rdata  = '0;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] v;
            v = m_hold[i];
            foreach (pend_id[k]) if (pend_id[k] == i) begin
                v = pend_data[k];
                e_rvalid[i] = 1'b1;
            end
            e_rdata = e_rdata | ((N*DW)'(v) << (i * DW));
        end
    endtask

    task automatic model_commit();
        int            nid[$];
        logic [DW-1:0] nd[$];
        foreach (pend_id[k]) m_hold[pend_id[k]] = pend_data[k];
        if (e_c1 >= 0 && !is_wr(e_c1)) begin nid.push_back(e_c1); nd.push_back(m_mem[addr_of(e_c1)]); end
        if (e_c2 >= 0 && !is_wr(e_c2)) begin nid.push_back(e_c2); nd.push_back(m_mem[addr_of(e_c2)]); end
        if (e_c1 >= 0 && is_wr(e_c1)) m_mem[addr_of(e_c1)] = wd_of(e_c1);
        if (e_c2 >= 0 && is_wr(e_c2)) m_mem[addr_of(e_c2)] = wd_of(e_c2);
        if (e_c1 >= 0) m_last1 = addr_of(e_c1);
        if (e_c2 >= 0) m_last2 = addr_of(e_c2);
        if (e_c2 >= 0)      m_ptr = (e_c2 + 1) % N;
        else if (e_c1 >= 0) m_ptr = (e_c1 + 1) % N;
        if (e_conf && m_cc < 65535) m_cc++;
        pend_id = nid; pend_data = nd;
    endtask

    task automatic check_model();
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("en", 64'(en), 64'(e_en));
        chk("wr1", 64'(wr1), 64'(e_wr1));
        chk("wr2", 64'(wr2), 64'(e_wr2));
        chk("add_1", 64'(add_1), 64'(e_add1));
        chk("add_2", 64'(add_2), 64'(e_add2));
        chk("data_1", 64'(data_1), 64'(e_d1));
        chk("data_2", 64'(data_2), 64'(e_d2));
        chk("rvalid", 64'(rvalid), 64'(e_rvalid));
        chk("rdata", 64'(rdata), 64'(e_rdata));
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cc));
`endif
    endtask

    // One cycle: called at a negedge with inputs already driven.
    task automatic step();
        #1;
        model_eval();
        check_model();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0]    req, wr;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]    gnt;
        logic            en, wr1, wr2;
        logic [AW-1:0]   a1, a2;
        logic [DW-1:0]   d1, d2;
        logic [N-1:0]    rvalid;
        logic [N*DW-1:0] rdata;
    } vec_t;

    vec_t tbl[9];
    logic [N-1:0] fair_exp[4];

    initial begin
        tbl[0] = '{4'b0011, 4'b0011, 16'h0021, 32'h0000BCAB, 4'b0011, 1, 1, 1, 4'd1, 4'd2, 8'hAB, 8'hBC, 4'b0000, 32'h00000000};
        tbl[1] = '{4'b1100, 4'b0000, 16'h2100, 32'h00000000, 4'b1100, 1, 0, 0, 4'd1, 4'd2, 8'h00, 8'h00, 4'b0000, 32'h00000000};
        tbl[2] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 0, 0, 0, 4'd1, 4'd2, 8'h00, 8'h00, 4'b1100, 32'hBCAB0000};
        tbl[3] = '{4'b0011, 4'b0001, 16'h0033, 32'h000000CD, 4'b0001, 1, 1, 0, 4'd3, 4'd2, 8'hCD, 8'h00, 4'b0000, 32'hBCAB0000};
        tbl[4] = '{4'b0010, 4'b0000, 16'h0030, 32'h00000000, 4'b0010, 1, 0, 0, 4'd3, 4'd2, 8'h00, 8'h00, 4'b0000, 32'hBCAB0000};
        tbl[5] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 0, 0, 0, 4'd3, 4'd2, 8'h00, 8'h00, 4'b0010, 32'hBCABCD00};
        tbl[6] = '{4'b0001, 4'b0001, 16'h0004, 32'h000000DE, 4'b0001, 1, 1, 0, 4'd4, 4'd2, 8'hDE, 8'h00, 4'b0000, 32'hBCABCD00};
        tbl[7] = '{4'b0110, 4'b0000, 16'h0440, 32'h00000000, 4'b0110, 1, 0, 0, 4'd4, 4'd4, 8'h00, 8'h00, 4'b0000, 32'hBCABCD00};
        tbl[8] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 0, 0, 0, 4'd4, 4'd4, 8'h00, 8'h00, 4'b0110, 32'hBCDEDE00};
        fair_exp[0] = 4'b0011; fair_exp[1] = 4'b1100; fair_exp[2] = 4'b0011; fair_exp[3] = 4'b1100;

        // Reset with all requests raised: grant must stay low.
        rst = 1'b1; req = '1; wr_req = '0; addr_req = '0; wdata_req = '0;
        model_reset();
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_ports", 64'({wr1, wr2, add_1, add_2, data_1, data_2}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 9; r++) begin
            req = tbl[r].req; wr_req = tbl[r].wr; addr_req = tbl[r].addr; wdata_req = tbl[r].wdata;
            #1;
            chk($sformatf("t%0d_gnt", r), 64'(gnt), 64'(tbl[r].gnt));
            chk($sformatf("t%0d_en", r), 64'(en), 64'(tbl[r].en));
            chk($sformatf("t%0d_wr", r), 64'({wr1, wr2}), 64'({tbl[r].wr1, tbl[r].wr2}));
            chk($sformatf("t%0d_add", r), 64'({add_1, add_2}), 64'({tbl[r].a1, tbl[r].a2}));
            chk($sformatf("t%0d_data", r), 64'({data_1, data_2}), 64'({tbl[r].d1, tbl[r].d2}));
            chk($sformatf("t%0d_rvalid", r), 64'(rvalid), 64'(tbl[r].rvalid));
            chk($sformatf("t%0d_rdata", r), 64'(rdata), 64'(tbl[r].rdata));
            model_eval();
            check_model();
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt_one", 64'(conflict_cnt), 64'd1);
`endif

        // Fairness: reset, then all four reads held continuously.
        rst = 1'b1; req = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111; wr_req = '0; addr_req = 16'h8765; wdata_req = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("fair%0d_gnt", c), 64'(gnt), 64'(fair_exp[c]));
            model_eval();
            check_model();
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
        req = '0;
        step();

        // Async reset mid-cycle right after a read grant.
        req = 4'b1111;
        #1;
        model_eval();
        check_model();
        @(posedge clk);
        model_commit();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_en", 64'(en), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_gnt", 64'(gnt), 64'(4'b0011));
        chk("postrst_rvalid", 64'(rvalid), 64'd0);
        model_eval();
        check_model();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        req = '0;
        step();

        // Random traffic on a narrow address range to provoke conflicts.
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i] || (!req[i] && $urandom_range(2, 0) == 0)) begin
                    if (e_gnt[i] && $urandom_range(1, 0) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        req[i]                = 1'b1;
                        wr_req[i]             = 1'($urandom_range(1, 0));
                        addr_req[i*AW +: AW]  = AW'($urandom_range(3, 0));
                        wdata_req[i*DW +: DW] = DW'($urandom_range(255, 0));
                    end
                end
            end
        end
        req = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
